// File: rtl/disp_scan_ctrl_pkg.sv
// Shared definitions for the display scan controller: scan state encoding
// and the hex-to-7-segment glyph table that the calculator datapath also uses.
package disp_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  localparam logic [7:0] SEG_DARK = 8'hFF;

  // Active-low {g,f,e,d,c,b,a}; b and d are drawn lowercase.
  function automatic logic [6:0] hex7_n(input logic [3:0] nib);
    logic [6:0] p;
    case (nib)
      4'h0: p = 7'h40;
      4'h1: p = 7'h79;
      4'h2: p = 7'h24;
      4'h3: p = 7'h30;
      4'h4: p = 7'h19;
      4'h5: p = 7'h12;
      4'h6: p = 7'h02;
      4'h7: p = 7'h78;
      4'h8: p = 7'h00;
      4'h9: p = 7'h10;
      4'hA: p = 7'h08;
      4'hB: p = 7'h03;
      4'hC: p = 7'h46;
      4'hD: p = 7'h21;
      4'hE: p = 7'h06;
      4'hF: p = 7'h0E;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_hex_to_seg.sv
// Combinational nibble to active-low segment decoder (dp handled by the caller).
module hex_to_seg
  import disp_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = hex7_n(nib_i);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed common-anode 7-seg scanner: BLANK gap then DRIVE per digit,
// paced by the prescaler tick, with per-digit decimal point and blink.
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int BLANK_TICKS = 1,
  parameter int ON_TICKS    = 3,
  parameter int BLINK_DIV   = 256,
  localparam int SELW       = $clog2(NDIG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              en,
  input  logic [4*NDIG-1:0] digits,
  input  logic [NDIG-1:0]   dp_mask,
  input  logic [NDIG-1:0]   blink_mask,
  output logic [NDIG-1:0]   an_n,
  output logic [7:0]        seg_n,
  output logic [SELW-1:0]   dig_sel,
  output logic              frame_done
);

  localparam int PMAX = (BLANK_TICKS > ON_TICKS) ? BLANK_TICKS : ON_TICKS;
  localparam int PCW  = $clog2(PMAX + 1);
  localparam int BW   = $clog2(BLINK_DIV);

  localparam logic [PCW-1:0]  BLANK_LAST = PCW'(BLANK_TICKS - 1);
  localparam logic [PCW-1:0]  ON_LAST    = PCW'(ON_TICKS - 1);
  localparam logic [SELW-1:0] DIG_LAST   = SELW'(NDIG - 1);

  scan_state_e     state_q, state_d;
  logic [PCW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_ph_q, blink_ph_d;
  logic [SELW-1:0] dig_sel_q, dig_sel_d;
  logic [NDIG-1:0] an_q, an_d;
  logic [7:0]      seg_q, seg_d;
  logic            fd_q, fd_d;

  logic [NDIG-1:0][3:0] dig_arr;
  logic [6:0]           seg7_n;
  logic                 blank_done, drive_done, last_dig;

  assign dig_arr    = digits;
  assign blank_done = tick && (cnt_q == BLANK_LAST);
  assign drive_done = tick && (cnt_q == ON_LAST);
  assign last_dig   = (dig_sel_q == DIG_LAST);

  hex_to_seg u_dec (
    .nib_i   (dig_arr[dig_sel_q]),
    .seg_n_o (seg7_n)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      dig_sel_q   <= '0;
      an_q        <= '1;
      seg_q       <= SEG_DARK;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      dig_sel_q   <= dig_sel_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      fd_q        <= fd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dig_sel_d   = dig_sel_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (!en) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      dig_sel_d   = '0;
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else begin
      // Blink timebase free-runs across the whole scan, independent of slots.
      if (tick && state_q != ST_IDLE) begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        if (&blink_cnt_q) blink_ph_d = ~blink_ph_q;
      end
      unique case (state_q)
        ST_IDLE: begin
          state_d   = ST_BLANK;
          cnt_d     = '0;
          dig_sel_d = '0;
        end
        ST_BLANK: if (tick) begin
          if (blank_done) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DRIVE: if (tick) begin
          if (drive_done) begin
            state_d   = ST_BLANK;
            cnt_d     = '0;
            dig_sel_d = last_dig ? '0 : dig_sel_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    fd_d  = 1'b0;
    if (!en || state_q == ST_IDLE) begin
      an_d  = '1;
      seg_d = SEG_DARK;
    end else if (state_q == ST_BLANK && blank_done) begin
      // Inputs are captured here only; the glyph is held for the whole DRIVE.
      seg_d = {~dp_mask[dig_sel_q], seg7_n};
      an_d  = '1;
      if (!(blink_ph_q && blink_mask[dig_sel_q])) an_d[dig_sel_q] = 1'b0;
    end else if (state_q == ST_DRIVE && drive_done) begin
      an_d  = '1;
      seg_d = SEG_DARK;
      fd_d  = last_dig;
    end
  end

  assign an_n       = an_q;
  assign seg_n      = seg_q;
  assign dig_sel    = dig_sel_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: vector table, directed corner sequences and a
// randomized run, all scored against a tick-count model of the scan.
module tb_disp_scan_ctrl;

  localparam int NDIG = 4;
  localparam int BT   = 1;
  localparam int OT   = 3;
  localparam int BD   = 32;
  localparam int SLOT = BT + OT;

  logic        clk = 1'b0;
  logic        rst = 1'b0, tick = 1'b0, en = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_mask = '0, blink_mask = '0;
  logic [3:0]  an_n;
  logic [7:0]  seg_n;
  logic [1:0]  dig_sel;
  logic        frame_done;

  int n_chk = 0;
  int n_err = 0;

  disp_scan_ctrl #(
    .NDIG(NDIG), .BLANK_TICKS(BT), .ON_TICKS(OT), .BLINK_DIV(BD)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .en(en),
    .digits(digits), .dp_mask(dp_mask), .blink_mask(blink_mask),
    .an_n(an_n), .seg_n(seg_n), .dig_sel(dig_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: position in the frame is just the number of ticks seen since enable.
  bit         m_act = 0;
  int         m_t = 0;
  logic [3:0] m_an = '1;
  logic [7:0] m_seg = 8'hFF;
  logic [1:0] m_sel = '0;
  logic       m_fd = 1'b0;

  task automatic model_edge();
    int p, slot, w;
    m_fd = 1'b0;
    if (!rst || !en) begin
      m_act = 0; m_t = 0; m_an = '1; m_seg = 8'hFF; m_sel = '0;
    end else if (!m_act) begin
      m_act = 1; m_t = 0;
    end else if (tick) begin
      p    = (m_t + 1) % (NDIG * SLOT);
      slot = p / SLOT;
      w    = p % SLOT;
      if (w == BT) begin
        m_seg = {~dp_mask[slot], glyph[digits[slot*4 +: 4]]};
        m_an  = '1;
        if (!(((m_t / BD) % 2 == 1) && blink_mask[slot])) m_an[slot] = 1'b0;
      end else if (w == 0) begin
        m_an  = '1;
        m_seg = 8'hFF;
        m_fd  = (p == 0);
      end
      m_sel = slot[1:0];
      m_t++;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit t);
    rst = r; en = e; tick = t;
    @(posedge clk);
    model_edge();
    #1;
    chk("an_n", {28'd0, an_n}, {28'd0, m_an});
    chk("seg_n", {24'd0, seg_n}, {24'd0, m_seg});
    chk("dig_sel", {30'd0, dig_sel}, {30'd0, m_sel});
    chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
  endtask

  task automatic tick10();
    step(1, 1, 1);
    repeat (9) step(1, 1, 0);
  endtask

  task automatic expect_out(input string nm, input logic [3:0] an, input logic [7:0] seg,
                            input logic [1:0] sel);
    chk({nm, "_an"}, {28'd0, an_n}, {28'd0, an});
    chk({nm, "_seg"}, {24'd0, seg_n}, {24'd0, seg});
    chk({nm, "_sel"}, {30'd0, dig_sel}, {30'd0, sel});
  endtask

  typedef struct {
    bit         r, e, t;
    int         gap;
    logic [3:0] an;
    logic [7:0] seg;
    logic [1:0] sel;
    bit         fd;
  } vec_t;

  vec_t vt[20];

  initial begin
    // Reset with tick/en active, then one full frame of 16'h1234.
    vt[0]  = '{0, 1, 1, 0, 4'hF, 8'hFF, 2'd0, 0};
    vt[1]  = '{0, 1, 1, 0, 4'hF, 8'hFF, 2'd0, 0};
    vt[2]  = '{0, 1, 1, 0, 4'hF, 8'hFF, 2'd0, 0};
    vt[3]  = '{1, 1, 0, 9, 4'hF, 8'hFF, 2'd0, 0};
    vt[4]  = '{1, 1, 1, 9, 4'hE, 8'h99, 2'd0, 0};
    vt[5]  = '{1, 1, 1, 9, 4'hE, 8'h99, 2'd0, 0};
    vt[6]  = '{1, 1, 1, 9, 4'hE, 8'h99, 2'd0, 0};
    vt[7]  = '{1, 1, 1, 9, 4'hF, 8'hFF, 2'd1, 0};
    vt[8]  = '{1, 1, 1, 9, 4'hD, 8'hB0, 2'd1, 0};
    vt[9]  = '{1, 1, 1, 9, 4'hD, 8'hB0, 2'd1, 0};
    vt[10] = '{1, 1, 1, 9, 4'hD, 8'hB0, 2'd1, 0};
    vt[11] = '{1, 1, 1, 9, 4'hF, 8'hFF, 2'd2, 0};
    vt[12] = '{1, 1, 1, 9, 4'hB, 8'hA4, 2'd2, 0};
    vt[13] = '{1, 1, 1, 9, 4'hB, 8'hA4, 2'd2, 0};
    vt[14] = '{1, 1, 1, 9, 4'hB, 8'hA4, 2'd2, 0};
    vt[15] = '{1, 1, 1, 9, 4'hF, 8'hFF, 2'd3, 0};
    vt[16] = '{1, 1, 1, 9, 4'h7, 8'hF9, 2'd3, 0};
    vt[17] = '{1, 1, 1, 9, 4'h7, 8'hF9, 2'd3, 0};
    vt[18] = '{1, 1, 1, 9, 4'h7, 8'hF9, 2'd3, 0};
    vt[19] = '{1, 1, 1, 9, 4'hF, 8'hFF, 2'd0, 1};

    digits = 16'h1234;
    for (int i = 0; i < 20; i++) begin
      step(vt[i].r, vt[i].e, vt[i].t);
      expect_out($sformatf("vec%0d", i), vt[i].an, vt[i].seg, vt[i].sel);
      chk($sformatf("vec%0d_fd", i), {31'd0, frame_done}, {31'd0, vt[i].fd});
      repeat (vt[i].gap) step(1, 1, 0);
    end

    // Sampling and dp: digit0 captured at DRIVE entry, later edits ignored.
    dp_mask = 4'b0001;
    tick10();
    expect_out("dp_d0", 4'hE, 8'h19, 2'd0);
    digits = 16'h1238;
    tick10();
    expect_out("hold_d0", 4'hE, 8'h19, 2'd0);
    tick10();
    tick10();
    expect_out("blank_d1", 4'hF, 8'hFF, 2'd1);
    tick10();
    expect_out("nodp_d1", 4'hD, 8'hB0, 2'd1);
    repeat (12) tick10();
    expect_out("resample_d0", 4'hE, 8'h00, 2'd0);

    // en drop mid-DRIVE of digit2 with a simultaneous tick.
    repeat (9) tick10();
    expect_out("mid_d2", 4'hB, 8'hA4, 2'd2);
    step(1, 0, 1);
    expect_out("en_off", 4'hF, 8'hFF, 2'd0);
    step(1, 1, 0);
    expect_out("re_en", 4'hF, 8'hFF, 2'd0);
    tick10();
    expect_out("re_en_d0", 4'hE, 8'h00, 2'd0);

    // Back-to-back ticks consume one digit slot in four clocks.
    repeat (3) tick10();
    expect_out("b2b_start", 4'hF, 8'hFF, 2'd1);
    repeat (4) step(1, 1, 1);
    expect_out("b2b_end", 4'hF, 8'hFF, 2'd2);
    tick10();
    expect_out("pre_rst", 4'hB, 8'hA4, 2'd2);
    step(0, 1, 1);
    expect_out("rst_drive", 4'hF, 8'hFF, 2'd0);

    // Blink on digit0: suppressed only when the DRIVE starts in phase 1.
    digits = 16'h1234; dp_mask = '0; blink_mask = 4'b0001;
    step(1, 1, 0);
    for (int k = 1; k <= 66; k++) begin
      tick10();
      if (k == 1 || k == 17 || k == 65) expect_out($sformatf("blink_on_k%0d", k), 4'hE, 8'h99, 2'd0);
      if (k == 33 || k == 49) expect_out($sformatf("blink_off_k%0d", k), 4'hF, 8'h99, 2'd0);
      if (k == 37) expect_out("blink_other", 4'hD, 8'hB0, 2'd1);
    end

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(49) == 0) digits = 16'($urandom);
      if ($urandom_range(49) == 0) dp_mask = 4'($urandom);
      if ($urandom_range(49) == 0) blink_mask = 4'($urandom);
      step($urandom_range(999) != 0, $urandom_range(399) != 0, $urandom_range(2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
